alu_issue_ctrl: RTL and testbench

- Multi-cycle issue controller that drives the CR16 ALU (`alu`).
- Accepts one 16-bit instruction per valid/ready handshake and decodes it into ALU opcode and operands.
- Reads the register file, captures the ALU result and status, owns the processor status register (PSR), issues register writeback, and evaluates branch condition codes against the PSR.
- Sits between instruction fetch and the ALU/register file.

---
 rtl/alu_issue_ctrl_pkg.sv | 99 +++++++++
 rtl/alu_issue_ctrl_decoder.sv | 128 ++++++++++++
 rtl/alu_issue_ctrl.sv | 127 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the CR16 ALU issue controller: ALU opcodes, status
// bit positions, instruction op/ext codes, condition codes and FSM states.
package alu_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_ADDU  = 4'd1,
    ALU_ADDC  = 4'd2,
    ALU_ADDCU = 4'd3,
    ALU_SUB   = 4'd4,
    ALU_MUL   = 4'd5,
    ALU_AND   = 4'd6,
    ALU_OR    = 4'd7,
    ALU_XOR   = 4'd8,
    ALU_NOT   = 4'd9,
    ALU_LSH   = 4'd10,
    ALU_RSH   = 4'd11,
    ALU_ALSH  = 4'd12,
    ALU_ARSH  = 4'd13
  } alu_op_e;

  // Status / PSR bit positions
  localparam int unsigned ST_C = 0;
  localparam int unsigned ST_L = 1;
  localparam int unsigned ST_F = 2;
  localparam int unsigned ST_Z = 3;
  localparam int unsigned ST_N = 4;

  // Instruction [15:12] op codes
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  // R-type [7:4] ext codes
  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_OR   = 4'b0010;
  localparam logic [3:0] EXT_XOR  = 4'b0011;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_ADDU = 4'b0110;
  localparam logic [3:0] EXT_ADDC = 4'b0111;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_NOT  = 4'b1010;
  localparam logic [3:0] EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_MOV  = 4'b1101;
  localparam logic [3:0] EXT_MUL  = 4'b1110;

  // Branch condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_LO = 4'b0100;
  localparam logic [3:0] COND_HS = 4'b0101;
  localparam logic [3:0] COND_MI = 4'b0110;
  localparam logic [3:0] COND_PL = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_HI = 4'b1010;
  localparam logic [3:0] COND_LS = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;

  typedef enum logic [1:0] {SEL_A_RSRC, SEL_A_RDEST, SEL_A_IMM} a_sel_e;
  typedef enum logic [1:0] {SEL_B_RDEST, SEL_B_ZERO, SEL_B_SHAMT, SEL_B_EIGHT} b_sel_e;
  typedef enum logic {IMM_ZEXT, IMM_SEXT} imm_mode_e;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [4:0] psr);
    logic res;
    case (cond)
      COND_EQ: res = psr[ST_Z];
      COND_NE: res = !psr[ST_Z];
      COND_CS: res = psr[ST_C];
      COND_CC: res = !psr[ST_C];
      COND_LO: res = psr[ST_L];
      COND_HS: res = !psr[ST_L];
      COND_MI: res = psr[ST_N];
      COND_PL: res = !psr[ST_N];
      COND_FS: res = psr[ST_F];
      COND_FC: res = !psr[ST_F];
      COND_HI: res = !psr[ST_L] && !psr[ST_Z];
      COND_LS: res = psr[ST_L] || psr[ST_Z];
      COND_GT: res = !psr[ST_N] && !psr[ST_Z];
      COND_LE: res = psr[ST_N] || psr[ST_Z];
      COND_UC: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_decoder.sv
// Combinational instruction decoder: ALU opcode, operand selects, extended
// immediate, and writeback / PSR-update / illegal qualifiers.
module alu_issue_ctrl_decoder
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned P_WIDTH = 16
) (
  input  logic [15:0]        instr,
  output alu_op_e            alu_opcode,
  output a_sel_e             a_sel,
  output b_sel_e             b_sel,
  output logic [3:0]         rdest,
  output logic [3:0]         rsrc,
  output logic [P_WIDTH-1:0] imm,
  output logic [P_WIDTH-1:0] shamt,
  output logic               wb_en,
  output logic               psr_en,
  output logic               illegal
);

  imm_mode_e imm_mode;

  assign rdest = instr[11:8];
  assign rsrc  = instr[3:0];
  assign shamt = P_WIDTH'(instr[3:0]);
  assign imm   = (imm_mode == IMM_SEXT) ? {{(P_WIDTH-8){instr[7]}}, instr[7:0]}
                                        : P_WIDTH'(instr[7:0]);

  // Decode op/ext fields into ALU control and instruction qualifiers
  always_comb begin
    alu_opcode = ALU_ADD;
    a_sel      = SEL_A_RSRC;
    b_sel      = SEL_B_RDEST;
    imm_mode   = IMM_ZEXT;
    wb_en      = 1'b1;
    psr_en     = 1'b1;
    illegal    = 1'b0;
    case (instr[15:12])
      OP_RTYPE: begin
        case (instr[7:4])
          EXT_AND:  alu_opcode = ALU_AND;
          EXT_OR:   alu_opcode = ALU_OR;
          EXT_XOR:  alu_opcode = ALU_XOR;
          EXT_ADD:  alu_opcode = ALU_ADD;
          EXT_ADDU: alu_opcode = ALU_ADDU;
          EXT_ADDC: alu_opcode = ALU_ADDC;
          EXT_SUB:  alu_opcode = ALU_SUB;
          EXT_NOT: begin
            alu_opcode = ALU_NOT;
            b_sel      = SEL_B_ZERO;
          end
          EXT_CMP: begin
            alu_opcode = ALU_SUB;
            wb_en      = 1'b0;
          end
          EXT_MOV: begin
            alu_opcode = ALU_OR;
            b_sel      = SEL_B_ZERO;
            psr_en     = 1'b0;
          end
          EXT_MUL: begin
            alu_opcode = ALU_MUL;
            psr_en     = 1'b0;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_ANDI: begin
        alu_opcode = ALU_AND;
        a_sel      = SEL_A_IMM;
      end
      OP_ORI: begin
        alu_opcode = ALU_OR;
        a_sel      = SEL_A_IMM;
      end
      OP_XORI: begin
        alu_opcode = ALU_XOR;
        a_sel      = SEL_A_IMM;
      end
      OP_ADDI: begin
        alu_opcode = ALU_ADD;
        a_sel      = SEL_A_IMM;
        imm_mode   = IMM_SEXT;
      end
      OP_SUBI: begin
        alu_opcode = ALU_SUB;
        a_sel      = SEL_A_IMM;
        imm_mode   = IMM_SEXT;
      end
      OP_CMPI: begin
        alu_opcode = ALU_SUB;
        a_sel      = SEL_A_IMM;
        imm_mode   = IMM_SEXT;
        wb_en      = 1'b0;
      end
      OP_MOVI: begin
        alu_opcode = ALU_ADD;
        a_sel      = SEL_A_IMM;
        b_sel      = SEL_B_ZERO;
        imm_mode   = IMM_SEXT;
        psr_en     = 1'b0;
      end
      OP_LUI: begin
        alu_opcode = ALU_LSH;
        a_sel      = SEL_A_IMM;
        b_sel      = SEL_B_EIGHT;
        psr_en     = 1'b0;
      end
      OP_SHIFT: begin
        a_sel = SEL_A_RDEST;
        b_sel = SEL_B_SHAMT;
        case (instr[7:6])
          2'b00:   alu_opcode = ALU_LSH;
          2'b01:   alu_opcode = ALU_RSH;
          2'b10:   alu_opcode = ALU_ALSH;
          default: alu_opcode = ALU_ARSH;
        endcase
        if (instr[5:4] != 2'b00) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      wb_en  = 1'b0;
      psr_en = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Three-cycle issue controller (IDLE -> EXEC -> WB) in front of the CR16 ALU.
// Owns the PSR and evaluates branch conditions against it.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned P_WIDTH = 16
) (
  input  logic               I_CLK,
  input  logic               I_NRESET,
  input  logic [15:0]        I_INSTR,
  input  logic               I_INSTR_VALID,
  output logic               O_INSTR_READY,
  output logic [3:0]         O_RA_ADDR,
  output logic [3:0]         O_RB_ADDR,
  input  logic [P_WIDTH-1:0] I_RA_DATA,
  input  logic [P_WIDTH-1:0] I_RB_DATA,
  output logic               O_ALU_ENABLE,
  output logic [3:0]         O_ALU_OPCODE,
  output logic [P_WIDTH-1:0] O_ALU_A,
  output logic [P_WIDTH-1:0] O_ALU_B,
  input  logic [P_WIDTH-1:0] I_ALU_C,
  input  logic [4:0]         I_ALU_STATUS,
  output logic               O_WB_EN,
  output logic [3:0]         O_WB_ADDR,
  output logic [P_WIDTH-1:0] O_WB_DATA,
  output logic [4:0]         O_PSR,
  input  logic [3:0]         I_COND,
  output logic               O_COND_TRUE,
  output logic               O_ILLEGAL
);

  state_e             state, state_next;
  logic [15:0]        instr_q;
  logic [P_WIDTH-1:0] result_q;
  logic [4:0]         psr_q;

  alu_op_e            dec_opcode;
  a_sel_e             dec_a_sel;
  b_sel_e             dec_b_sel;
  logic [3:0]         dec_rdest, dec_rsrc;
  logic [P_WIDTH-1:0] dec_imm, dec_shamt;
  logic               dec_wb_en, dec_psr_en, dec_illegal;

  alu_issue_ctrl_decoder #(.P_WIDTH(P_WIDTH)) u_decoder (
    .instr      (instr_q),
    .alu_opcode (dec_opcode),
    .a_sel      (dec_a_sel),
    .b_sel      (dec_b_sel),
    .rdest      (dec_rdest),
    .rsrc       (dec_rsrc),
    .imm        (dec_imm),
    .shamt      (dec_shamt),
    .wb_en      (dec_wb_en),
    .psr_en     (dec_psr_en),
    .illegal    (dec_illegal)
  );

  // State register
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) state <= S_IDLE;
    else           state <= state_next;
  end

  // Next state and per-state control strobes
  always_comb begin
    state_next    = state;
    O_INSTR_READY = 1'b0;
    O_ALU_ENABLE  = 1'b0;
    O_WB_EN       = 1'b0;
    O_ILLEGAL     = 1'b0;
    case (state)
      S_IDLE: begin
        O_INSTR_READY = 1'b1;
        if (I_INSTR_VALID) state_next = S_EXEC;
      end
      S_EXEC: begin
        O_ALU_ENABLE = !dec_illegal;
        state_next   = S_WB;
      end
      S_WB: begin
        O_WB_EN    = dec_wb_en;
        O_ILLEGAL  = dec_illegal;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Instruction capture on accept; result and PSR capture at the end of EXEC
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      instr_q  <= '0;
      result_q <= '0;
      psr_q    <= '0;
    end else begin
      if (state == S_IDLE && I_INSTR_VALID) instr_q <= I_INSTR;
      if (state == S_EXEC) begin
        result_q <= I_ALU_C;
        if (dec_psr_en) psr_q <= I_ALU_STATUS;
      end
    end
  end

  // ALU operand selection
  always_comb begin
    case (dec_a_sel)
      SEL_A_RDEST: O_ALU_A = I_RA_DATA;
      SEL_A_IMM:   O_ALU_A = dec_imm;
      default:     O_ALU_A = I_RB_DATA;
    endcase
    case (dec_b_sel)
      SEL_B_ZERO:  O_ALU_B = '0;
      SEL_B_SHAMT: O_ALU_B = dec_shamt;
      SEL_B_EIGHT: O_ALU_B = P_WIDTH'(8);
      default:     O_ALU_B = I_RA_DATA;
    endcase
  end

  assign O_ALU_OPCODE = dec_opcode;
  assign O_RA_ADDR    = dec_rdest;
  assign O_RB_ADDR    = dec_rsrc;
  assign O_WB_ADDR    = dec_rdest;
  assign O_WB_DATA    = result_q;
  assign O_PSR        = psr_q;
  assign O_COND_TRUE  = cond_eval(I_COND, psr_q);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: register file and ALU behavioural stand-ins,
// plus an instruction-level reference model.
module tb_alu_issue_ctrl;

  logic        I_CLK = 1'b0;
  logic        I_NRESET;
  logic [15:0] I_INSTR;
  logic        I_INSTR_VALID;
  logic        O_INSTR_READY;
  logic [3:0]  O_RA_ADDR, O_RB_ADDR;
  logic [15:0] I_RA_DATA, I_RB_DATA;
  logic        O_ALU_ENABLE;
  logic [3:0]  O_ALU_OPCODE;
  logic [15:0] O_ALU_A, O_ALU_B, I_ALU_C;
  logic [4:0]  I_ALU_STATUS;
  logic        O_WB_EN;
  logic [3:0]  O_WB_ADDR;
  logic [15:0] O_WB_DATA;
  logic [4:0]  O_PSR;
  logic [3:0]  I_COND;
  logic        O_COND_TRUE;
  logic        O_ILLEGAL;

  int total = 0;
  int bad   = 0;
  logic [4:0] mdl_psr = '0;

  logic [15:0] regs [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  alu_issue_ctrl #(.P_WIDTH(16)) dut (
    .I_CLK(I_CLK), .I_NRESET(I_NRESET), .I_INSTR(I_INSTR), .I_INSTR_VALID(I_INSTR_VALID),
    .O_INSTR_READY(O_INSTR_READY), .O_RA_ADDR(O_RA_ADDR), .O_RB_ADDR(O_RB_ADDR),
    .I_RA_DATA(I_RA_DATA), .I_RB_DATA(I_RB_DATA), .O_ALU_ENABLE(O_ALU_ENABLE),
    .O_ALU_OPCODE(O_ALU_OPCODE), .O_ALU_A(O_ALU_A), .O_ALU_B(O_ALU_B), .I_ALU_C(I_ALU_C),
    .I_ALU_STATUS(I_ALU_STATUS), .O_WB_EN(O_WB_EN), .O_WB_ADDR(O_WB_ADDR),
    .O_WB_DATA(O_WB_DATA), .O_PSR(O_PSR), .I_COND(I_COND), .O_COND_TRUE(O_COND_TRUE),
    .O_ILLEGAL(O_ILLEGAL)
  );

  always #5 I_CLK = ~I_CLK;

  // Register file: DUT writeback plus bench preload port
  always @(posedge I_CLK) begin
    if (pre_we) regs[pre_addr] <= pre_data;
    else if (O_WB_EN) regs[O_WB_ADDR] <= O_WB_DATA;
  end

  always_comb begin
    I_RA_DATA = regs[O_RA_ADDR];
    I_RB_DATA = regs[O_RB_ADDR];
  end

  // Status word {N,Z,F,L,C}
  function automatic logic [4:0] st_plain(input logic [15:0] r);
    return {r[15], (r == 16'h0), 3'b000};
  endfunction

  function automatic logic [4:0] st_add(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] s;
    s = {1'b0, x} + {1'b0, y};
    return {s[15], (s[15:0] == 16'h0), (x[15] == y[15]) && (s[15] != x[15]), 1'b0, s[16]};
  endfunction

  // d - s
  function automatic logic [4:0] st_sub(input logic [15:0] d, input logic [15:0] s);
    logic [15:0] r;
    r = d - s;
    return {r[15], (r == 16'h0), (d[15] != s[15]) && (r[15] != d[15]), (d < s), (d < s)};
  endfunction

  // Behavioural ALU stand-in
  always_comb begin
    I_ALU_C = '0;
    I_ALU_STATUS = '0;
    case (O_ALU_OPCODE)
      4'd0, 4'd1, 4'd2, 4'd3: I_ALU_C = O_ALU_A + O_ALU_B;
      4'd4:  I_ALU_C = O_ALU_B - O_ALU_A;
      4'd5:  I_ALU_C = O_ALU_A * O_ALU_B;
      4'd6:  I_ALU_C = O_ALU_A & O_ALU_B;
      4'd7:  I_ALU_C = O_ALU_A | O_ALU_B;
      4'd8:  I_ALU_C = O_ALU_A ^ O_ALU_B;
      4'd9:  I_ALU_C = ~O_ALU_A;
      4'd10, 4'd12: I_ALU_C = O_ALU_A << O_ALU_B;
      4'd11: I_ALU_C = O_ALU_A >> O_ALU_B;
      4'd13: I_ALU_C = 16'($signed(O_ALU_A) >>> O_ALU_B);
      default: I_ALU_C = '0;
    endcase
    if (O_ALU_OPCODE <= 4'd3)      I_ALU_STATUS = st_add(O_ALU_A, O_ALU_B);
    else if (O_ALU_OPCODE == 4'd4) I_ALU_STATUS = st_sub(O_ALU_B, O_ALU_A);
    else                           I_ALU_STATUS = st_plain(I_ALU_C);
  end

  function automatic logic cond_ref(input logic [3:0] c, input logic [4:0] p);
    logic n, z, f, l, cy;
    {n, z, f, l, cy} = p;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return l;
      4'd5:  return !l;
      4'd6:  return n;
      4'd7:  return !n;
      4'd8:  return f;
      4'd9:  return !f;
      4'd10: return !l && !z;
      4'd11: return l || z;
      4'd12: return !n && !z;
      4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Instruction-level semantics: what the instruction should do to Rdest and the PSR
  task automatic model(input logic [15:0] ins, input logic [15:0] rd, input logic [15:0] rs,
                       input logic [4:0] pin, output logic ill, output logic wb,
                       output logic [3:0] op, output logic [15:0] data, output logic [4:0] pout);
    logic [15:0] zi, si;
    logic [3:0]  amt;
    zi = {8'h00, ins[7:0]};
    si = {{8{ins[7]}}, ins[7:0]};
    amt = ins[3:0];
    ill = 1'b0; wb = 1'b1; op = 4'd0; data = '0; pout = pin;
    case (ins[15:12])
      4'h0: case (ins[7:4])
        4'h1: begin op = 4'd6; data = rd & rs; pout = st_plain(data); end
        4'h2: begin op = 4'd7; data = rd | rs; pout = st_plain(data); end
        4'h3: begin op = 4'd8; data = rd ^ rs; pout = st_plain(data); end
        4'h5, 4'h6, 4'h7: begin
          op = 4'd0 + {2'b00, ins[5:4]} - 4'd1;
          data = rd + rs; pout = st_add(rs, rd);
        end
        4'h9: begin op = 4'd4; data = rd - rs; pout = st_sub(rd, rs); end
        4'hA: begin op = 4'd9; data = ~rs; pout = st_plain(data); end
        4'hB: begin op = 4'd4; wb = 1'b0; pout = st_sub(rd, rs); end
        4'hD: begin op = 4'd7; data = rs; end
        4'hE: begin op = 4'd5; data = rd * rs; end
        default: ill = 1'b1;
      endcase
      4'h1: begin op = 4'd6; data = rd & zi; pout = st_plain(data); end
      4'h2: begin op = 4'd7; data = rd | zi; pout = st_plain(data); end
      4'h3: begin op = 4'd8; data = rd ^ zi; pout = st_plain(data); end
      4'h5: begin op = 4'd0; data = rd + si; pout = st_add(si, rd); end
      4'h9: begin op = 4'd4; data = rd - si; pout = st_sub(rd, si); end
      4'hB: begin op = 4'd4; wb = 1'b0; pout = st_sub(rd, si); end
      4'hD: begin op = 4'd0; data = si; end
      4'hF: begin op = 4'd10; data = {ins[7:0], 8'h00}; end
      4'h8: begin
        if (ins[5:4] != 2'b00) ill = 1'b1;
        else begin
          case (ins[7:6])
            2'b00: begin op = 4'd10; data = rd << amt; end
            2'b01: begin op = 4'd11; data = rd >> amt; end
            2'b10: begin op = 4'd12; data = rd << amt; end
            default: begin op = 4'd13; data = 16'($signed(rd) >>> amt); end
          endcase
          pout = st_plain(data);
        end
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin wb = 1'b0; pout = pin; end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input logic [3:0] a, input logic [15:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(posedge I_CLK); #1;
    pre_we = 1'b0;
  endtask

  // Issue one instruction from IDLE and check EXEC, WB and return to IDLE
  task automatic run_instr(input logic [15:0] ins);
    logic ill, wb;
    logic [3:0] op;
    logic [15:0] d;
    logic [4:0] ps;
    model(ins, regs[ins[11:8]], regs[ins[3:0]], mdl_psr, ill, wb, op, d, ps);
    check("ready_idle", O_INSTR_READY, 1);
    I_INSTR = ins; I_INSTR_VALID = 1'b1;
    @(posedge I_CLK); #1;
    I_INSTR_VALID = 1'b0; I_INSTR = 16'($urandom);
    check("ready_exec", O_INSTR_READY, 0);
    check("alu_en", O_ALU_ENABLE, !ill);
    if (!ill) check("alu_op", O_ALU_OPCODE, op);
    check("wb_en_exec", O_WB_EN, 0);
    check("psr_exec", O_PSR, mdl_psr);
    @(posedge I_CLK); #1;
    check("wb_en", O_WB_EN, wb);
    if (wb) begin
      check("wb_addr", O_WB_ADDR, ins[11:8]);
      check("wb_data", O_WB_DATA, d);
    end
    check("illegal", O_ILLEGAL, ill);
    check("alu_en_wb", O_ALU_ENABLE, 0);
    check("psr", O_PSR, ps);
    I_COND = 4'($urandom); #1;
    check("cond", O_COND_TRUE, cond_ref(I_COND, ps));
    mdl_psr = ps;
    @(posedge I_CLK); #1;
    check("ready_back", O_INSTR_READY, 1);
    check("wb_en_idle", O_WB_EN, 0);
    check("illegal_idle", O_ILLEGAL, 0);
  endtask

  logic [3:0] rext [11] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE};
  logic [3:0] iops [8]  = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF};

  initial begin
    logic [15:0] ins;
    logic [15:0] r8;
    I_NRESET = 1'b0; I_INSTR = '0; I_INSTR_VALID = 1'b0; I_COND = '0;
    for (int i = 0; i < 16; i++) regs[i] = '0;
    repeat (2) @(posedge I_CLK);
    #1;
    check("rst_psr", O_PSR, 0);
    check("rst_wb_en", O_WB_EN, 0);
    check("rst_illegal", O_ILLEGAL, 0);
    check("rst_alu_en", O_ALU_ENABLE, 0);
    I_NRESET = 1'b1;
    @(posedge I_CLK); #1;
    check("rst_ready", O_INSTR_READY, 1);
    check("rst_wb_data", O_WB_DATA, 0);

    set_reg(4'd1, 16'h7FFF);
    set_reg(4'd2, 16'h0001);
    set_reg(4'd3, 16'h0005);
    set_reg(4'd4, 16'h0009);
    set_reg(4'd6, 16'h8001);
    set_reg(4'd8, 16'h1234);

    // ADD R1,R2: signed overflow into 0x8000
    run_instr(16'h0152);
    check("add_psr", O_PSR, 5'b10100);
    check("add_r1", regs[1], 16'h8000);

    // CMP R3,R4: no writeback, borrow/low/negative set
    run_instr(16'h03B4);
    check("cmp_psr", O_PSR, 5'b10011);
    check("cmp_r3", regs[3], 16'h0005);
    I_COND = 4'b0100; #1;
    check("cmp_cond_lo", O_COND_TRUE, 1);
    I_COND = 4'b1010; #1;
    check("cmp_cond_hi", O_COND_TRUE, 0);

    // XOR R7,R7 leaves only Z; LUI must not disturb it
    run_instr(16'h0737);
    check("xor_psr", O_PSR, 5'b01000);
    run_instr(16'hF5AB);
    check("lui_r5", regs[5], 16'hAB00);
    check("lui_psr", O_PSR, 5'b01000);

    // ARSH R6 by 1
    run_instr(16'h86C1);
    check("arsh_r6", regs[6], 16'hC000);

    // Illegal R-type ext
    run_instr(16'h0040);

    // Valid held high: accepted every third cycle
    r8 = regs[8];
    I_INSTR = 16'h5801; I_INSTR_VALID = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge I_CLK); #1;
      check("hold_ready", O_INSTR_READY, (k % 3) == 0);
      check("hold_wb_en", O_WB_EN, (k % 3) == 2);
    end
    I_INSTR_VALID = 1'b0;
    check("hold_r8", regs[8], r8 + 16'd3);
    mdl_psr = st_add(16'h0001, r8 + 16'd2);
    check("hold_psr", O_PSR, mdl_psr);

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      if (n % 8 == 0) set_reg(4'($urandom), 16'($urandom));
      ins = 16'($urandom);
      case ($urandom_range(0, 4))
        1: ins = {4'h0, ins[11:8], rext[$urandom_range(0, 10)], ins[3:0]};
        2: ins = {iops[$urandom_range(0, 7)], ins[11:0]};
        3: ins = {4'h8, ins[11:6], 2'b00, ins[3:0]};
        default: ;
      endcase
      run_instr(ins);
    end

    // Reset during EXEC aborts the instruction
    set_reg(4'd9, 16'h0001);
    set_reg(4'd10, 16'h0002);
    run_instr(16'h09BA);
    I_INSTR = 16'h099A; I_INSTR_VALID = 1'b1;
    @(posedge I_CLK); #1;
    I_INSTR_VALID = 1'b0;
    check("abort_exec_en", O_ALU_ENABLE, 1);
    I_NRESET = 1'b0; #1;
    check("abort_ready", O_INSTR_READY, 1);
    check("abort_psr", O_PSR, 0);
    check("abort_wb_en", O_WB_EN, 0);
    #2 I_NRESET = 1'b1;
    mdl_psr = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge I_CLK); #1;
      check("abort_no_wb", O_WB_EN, 0);
      check("abort_psr_hold", O_PSR, 0);
    end
    check("abort_r9", regs[9], 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
